// File: rtl/minmax_stream_9bit.sv
// Streaming sign-magnitude min/max reduction over windows of up to WINDOW operands.
// Latency: result valid the cycle after the closing operand is accepted.
// Backpressure: inReady drops while a result waits; outData/outIndex hold until outReady.
//
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   mode              - 0 = min, 1 = max; latched with the first operand of a window
//   inValid/inReady   - operand handshake; inData is sign-magnitude, inLast closes early
//   outValid/outReady - result handshake; outData is the winning operand bit pattern
//   outIndex          - window position of the winner (only with MINMAX_ARGINDEX_EN)
//
// Optional feature macro: MINMAX_ARGINDEX_EN adds the outIndex port and index register.

module minmax_stream_9bit #(
  parameter int WIDTH  = 9,
  parameter int WINDOW = 4,
  parameter int IDX_W  = $clog2(WINDOW)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inData,
  input  logic             inLast,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outData
`ifdef MINMAX_ARGINDEX_EN
  ,
  output logic [IDX_W-1:0] outIndex
`endif
);

  // One extra bit so the counter can represent WINDOW itself.
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_acc;
  logic             r_mode;
  logic [CNT_W-1:0] r_cnt;
`ifdef MINMAX_ARGINDEX_EN
  logic [IDX_W-1:0] r_idx;
`endif

  logic w_in_fire;
  logic w_out_fire;
  logic w_close;
  logic w_wins;
  logic signed [WIDTH-1:0] w_new_tc;
  logic signed [WIDTH-1:0] w_acc_tc;

  // Map sign-magnitude onto two's complement so that -0 and +0 both become 0
  // and an ordinary signed compare gives the required ordering. The largest
  // magnitude is 2^(WIDTH-1)-1, so the negation always fits in WIDTH bits.
  function automatic logic signed [WIDTH-1:0] sm_to_tc(input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] mag;
    mag = signed'({1'b0, v[WIDTH-2:0]});
    return v[WIDTH-1] ? -mag : mag;
  endfunction

  assign w_new_tc = sm_to_tc(inData);
  assign w_acc_tc = sm_to_tc(r_acc);

  // Strict comparison: on a tie (including -0 vs +0) the earlier operand stays.
  assign w_wins = r_mode ? (w_new_tc > w_acc_tc) : (w_new_tc < w_acc_tc);

  assign w_in_fire  = inValid && inReady;
  assign w_out_fire = outValid && outReady;

  // Window closes on an explicit last or when the WINDOW-th operand arrives.
  // From IDLE only inLast can close it since WINDOW is at least 2.
  assign w_close = inLast || ((r_state == S_ACCUM) && (r_cnt == LP_LAST));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs; both outputs depend on state only.
  always_comb begin
    w_state_nxt = r_state;
    inReady     = 1'b0;
    outValid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        inReady = 1'b1;
        if (w_in_fire) begin
          w_state_nxt = w_close ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        inReady = 1'b1;
        if (w_in_fire && w_close) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        outValid = 1'b1;
        if (outReady) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Accumulator, latched mode and operand count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc  <= '0;
      r_mode <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_in_fire && (r_state == S_IDLE)) begin
        r_acc  <= inData;
        r_mode <= mode;
        r_cnt  <= CNT_W'(1);
      end else if (w_in_fire && (r_state == S_ACCUM)) begin
        if (w_wins) begin
          r_acc <= inData;
        end
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_out_fire) begin
        r_cnt <= '0;
      end
    end
  end

  // The accumulator is only written while accepting operands, so it is
  // naturally stable for the whole DONE state.
  assign outData = r_acc;

`ifdef MINMAX_ARGINDEX_EN
  // The pre-increment count is the position of the operand being accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
    end else begin
      if (w_in_fire && (r_state == S_IDLE)) begin
        r_idx <= '0;
      end else if (w_in_fire && (r_state == S_ACCUM) && w_wins) begin
        r_idx <= r_cnt[IDX_W-1:0];
      end
    end
  end

  assign outIndex = r_idx;
`endif

endmodule

// File: tb/tb_minmax_stream_9bit.sv
module tb_minmax_stream_9bit;

  logic       clk;
  logic       reset;
  logic       mode;
  logic       inValid;
  logic       inReady;
  logic [8:0] inData;
  logic       inLast;
  logic       outValid;
  logic       outReady;
  logic [8:0] outData;
`ifdef MINMAX_ARGINDEX_EN
  logic [1:0] outIndex;
`endif

  minmax_stream_9bit #(.WIDTH(9), .WINDOW(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .inValid  (inValid),
    .inReady  (inReady),
    .inData   (inData),
    .inLast   (inLast),
    .outValid (outValid),
    .outReady (outReady),
    .outData  (outData)
`ifdef MINMAX_ARGINDEX_EN
    ,
    .outIndex (outIndex)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       m;
    logic [2:0] n;
    logic [3:0][8:0] ops;
    logic [8:0] exp_d;
    logic [1:0] exp_i;
  } vec_t;

  typedef struct packed {
    logic [8:0] d;
    logic [1:0] i;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic m, input int n,
                              input logic [8:0] o0, input logic [8:0] o1,
                              input logic [8:0] o2, input logic [8:0] o3,
                              input logic [8:0] ed, input logic [1:0] ei);
    vec_t v;
    v.m      = m;
    v.n      = 3'(n);
    v.ops[0] = o0;
    v.ops[1] = o1;
    v.ops[2] = o2;
    v.ops[3] = o3;
    v.exp_d  = ed;
    v.exp_i  = ei;
    return v;
  endfunction

  // Result monitor: compares every result transfer against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (outValid && outReady) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got data 0x%0h with no expected result", outData);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result_data", 32'(outData), 32'(e.d));
`ifdef MINMAX_ARGINDEX_EN
          chk("result_index", 32'(outIndex), 32'(e.i));
`endif
        end
      end
    end
  end

  // Drive one window starting at posedge+1; mode is inverted after the first
  // operand to show that only the first sample matters.
  task automatic send_window(input vec_t v);
    int nn;
    nn = int'(v.n);
    for (int k = 0; k < nn; k++) begin
      int g;
      g = 0;
      while (!inReady && g < 20) begin
        @(posedge clk); #1;
        g++;
      end
      if (!inReady) begin
        n_cmp++;
        n_bad++;
        $display("FAIL inReady_timeout: got 0 expected 1 within 20 cycles");
      end
      inValid = 1'b1;
      inData  = v.ops[k];
      inLast  = (k == nn - 1) && (nn < 4);
      mode    = (k == 0) ? v.m : ~v.m;
      if (k == nn - 1) q.push_back('{d: v.exp_d, i: v.exp_i});
      @(posedge clk); #1;
      if (k < nn - 1) begin
        chk("outValid_mid_window", 32'(outValid), 32'd0);
      end else begin
        chk("outValid_latency", 32'(outValid), 32'd1);
        chk("inReady_in_done", 32'(inReady), 32'd0);
      end
    end
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask

  vec_t tbl[12];

  initial begin
    // Min/max windows with expected results worked out by hand
    tbl[0]  = mk(0, 4, 9'h003, 9'h102, 9'h000, 9'h101, 9'h102, 2'd1);
    tbl[1]  = mk(1, 4, 9'h103, 9'h102, 9'h1FF, 9'h101, 9'h101, 2'd3);
    tbl[2]  = mk(0, 2, 9'h100, 9'h000, 9'h000, 9'h000, 9'h100, 2'd0);
    tbl[3]  = mk(1, 2, 9'h000, 9'h100, 9'h000, 9'h000, 9'h000, 2'd0);
    tbl[4]  = mk(1, 2, 9'h005, 9'h007, 9'h000, 9'h000, 9'h007, 2'd1);
    tbl[5]  = mk(1, 4, 9'h010, 9'h001, 9'h002, 9'h0FF, 9'h0FF, 2'd3);
    tbl[6]  = mk(0, 1, 9'h1AA, 9'h000, 9'h000, 9'h000, 9'h1AA, 2'd0);
    tbl[7]  = mk(1, 4, 9'h005, 9'h005, 9'h005, 9'h005, 9'h005, 2'd0);
    tbl[8]  = mk(0, 4, 9'h0FF, 9'h1FF, 9'h0FF, 9'h1FE, 9'h1FF, 2'd1);
    tbl[9]  = mk(0, 3, 9'h000, 9'h100, 9'h000, 9'h000, 9'h000, 2'd0);
    tbl[10] = mk(1, 4, 9'h1FF, 9'h000, 9'h100, 9'h001, 9'h001, 2'd3);
    tbl[11] = mk(0, 4, 9'h07F, 9'h040, 9'h100, 9'h0C0, 9'h100, 2'd2);

    reset    = 1'b1;
    mode     = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    inLast   = 1'b0;
    outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_inReady", 32'(inReady), 32'd1);
    chk("reset_outValid", 32'(outValid), 32'd0);
    chk("reset_outData", 32'(outData), 32'd0);
`ifdef MINMAX_ARGINDEX_EN
    chk("reset_outIndex", 32'(outIndex), 32'd0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 12; t++) begin
      send_window(tbl[t]);
    end
    drain();

    // Backpressure: result held for 5 cycles, junk operand offered meanwhile
    outReady = 1'b0;
    send_window(mk(1, 4, 9'h020, 9'h130, 9'h07E, 9'h011, 9'h07E, 2'd2));
    for (int c = 0; c < 5; c++) begin
      inValid = 1'b1;
      inData  = 9'h1FF;
      @(posedge clk); #1;
      chk("stall_inReady", 32'(inReady), 32'd0);
      chk("stall_outValid", 32'(outValid), 32'd1);
      chk("stall_outData", 32'(outData), 32'h07E);
`ifdef MINMAX_ARGINDEX_EN
      chk("stall_outIndex", 32'(outIndex), 32'd2);
`endif
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk); #1;
    chk("release_inReady", 32'(inReady), 32'd1);
    chk("release_outValid", 32'(outValid), 32'd0);
    // Next operand must be taken on the very next edge
    inValid = 1'b1;
    inData  = 9'h010;
    mode    = 1'b0;
    q.push_back('{d: 9'h010, i: 2'd0});
    inLast  = 1'b1;
    @(posedge clk); #1;
    chk("after_release_accept", 32'(outValid), 32'd1);
    inValid = 1'b0;
    inLast  = 1'b0;
    drain();

    // Reset in the middle of a window: two operands accepted, then abort
    inValid = 1'b1;
    mode    = 1'b0;
    inData  = 9'h1FF;
    @(posedge clk); #1;
    inData  = 9'h1FE;
    @(posedge clk); #1;
    inValid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_outValid", 32'(outValid), 32'd0);
    chk("midreset_inReady", 32'(inReady), 32'd1);
    chk("midreset_outData", 32'(outData), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send_window(mk(0, 4, 9'h005, 9'h003, 9'h009, 9'h004, 9'h003, 2'd1));
    drain();

    repeat (3) @(posedge clk);
    chk("no_leftover_results", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/minmax_stream_9bit.md
# minmax_stream_9bit

Streaming sign-magnitude min/max reduction unit for the TPU ALU datapath, the sequential successor to the 9-bit combinational min comparator. It accepts a stream of sign-magnitude operands over a valid/ready handshake, reduces each window of up to `WINDOW` operands to its minimum or maximum, and presents one result per window on a valid/ready output port. It sits between the activation buffer and the writeback stage and serves max-pooling and min/max-clipping passes.

## Interface
Parameters:
- `WIDTH`, 9: operand width; bit `WIDTH-1` is the sign (1 = negative), bits `WIDTH-2:0` are the magnitude. Must be at least 2.
- `WINDOW`, 4: maximum operands per window. Must be at least 2.
- `IDX_W`, `$clog2(WINDOW)`: derived index width; not overridden.

Ports:
- `clk` input 1: the block's single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `mode` input 1: 0 selects min, 1 selects max. Sampled only with the first operand of a window.
- `inValid` input 1: operand present.
- `inReady` output 1: block accepts an operand this cycle.
- `inData` input WIDTH: sign-magnitude operand.
- `inLast` input 1: qualified by `inValid`. Closes the window early at this operand.
- `outValid` output 1: result present.
- `outReady` input 1: consumer accepts the result.
- `outData` output WIDTH: reduced result.
- `outIndex` output IDX_W: position of the winning operand in the window. Present only with `ARGINDEX_EN`.

## Operation
- An operand transfer occurs when `inValid && inReady`. A result transfer occurs when `outValid && outReady`.
- The state machine has three states:
  - IDLE: no partial result. `inReady` is 1. An accepted operand loads the accumulator, latches `mode`, and sets count = 1. The next state is ACCUM, or DONE if `inLast` is set.
  - ACCUM: `inReady` is 1. Each accepted operand is compared with the accumulator, the winner replaces the accumulator, and count increments. The state moves to DONE when count reaches `WINDOW` or `inLast` is set.
  - DONE: `inReady` is 0 and `outValid` is 1. On a result transfer the state returns to IDLE.
- Comparison is sign-magnitude:
  - A negative operand is less than any non-negative one.
  - Two positives are ordered by magnitude ascending.
  - Two negatives are ordered by magnitude descending.
- Negative zero (`1_0…0`) compares equal to positive zero.
- On a tie the earlier operand is kept, including the -0/+0 tie. The stored bit pattern is returned unchanged.
- `mode` changes during ACCUM or DONE have no effect on the current window.
- `outData` and `outIndex` are held stable while `outValid` is high and `outReady` is low.
- `reset` clears the current window immediately, with no partial result emitted:
  - state returns to IDLE and count to 0;
  - the accumulator, `outData` and `outIndex` go to 0;
  - the latched mode goes to min.
- The block does no arithmetic beyond comparison, so there is no overflow case.

## Timing
- Reset values: `inReady` = 1, `outValid` = 0, `outData` = 0, `outIndex` = 0.
- Result latency: `outValid` rises on the clock edge that accepts the closing operand, so it is visible in the following cycle.
- Throughput: one operand per cycle within a window. Each window costs one DONE cycle if `outReady` is held high. A full window therefore takes `WINDOW`+1 cycles.
- There is no input-to-output combinational path. `inReady` depends only on state.
- A window of length 1 (`inLast` on the first operand) is legal. It yields that operand with index 0.

## Configuration
- `MINMAX_ARGINDEX_EN` defined:
  - `outIndex` exists;
  - an index register tracks the count value at which the current winner was accepted;
  - the register updates only when a new operand strictly wins.
- `MINMAX_ARGINDEX_EN` not defined:
  - the `outIndex` port and the index register are absent;
  - all other behaviour is identical.

## Test plan
All scenarios use WIDTH=9 and WINDOW=4.
- Min window: mode=0 with inputs 0x003, 0x102 (-2), 0x000, 0x101 (-1) -> outData=0x102, outIndex=1, with outValid in the cycle after the 4th accept.
- Max window of negatives: mode=1 with inputs 0x103, 0x102, 0x1FF, 0x101 -> outData=0x101, outIndex=3.
- Zero tie: mode=0 with 0x100 (-0) then 0x000 and inLast -> outData=0x100, outIndex=0. mode=1 with 0x000 then 0x100 and inLast -> outData=0x000.
- Backpressure: hold outReady=0 for 5 cycles after a window completes -> inReady=0 and outData stable throughout. Raising outReady for one cycle returns the block to IDLE, and the next operand is accepted in the following cycle.
- Early close: inLast on the 2nd operand of mode=1 with inputs 0x005, 0x007 -> outData=0x007. The next window counts from 0 again and accepts 4 operands.
- Reset mid-window: assert reset asynchronously after 2 accepted operands -> outValid=0, inReady=1 and outData=0 immediately. A following 4-operand window reduces correctly with no contamination from the aborted window.
